// File: rtl/sram_dma_pkg.sv
// sram_dma_pkg: shared FSM state codes and mode/direction constants for the SRAM DMA copier
package sram_dma_pkg;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
endpackage

// File: rtl/sram_dma_addr_gen.sv
// sram_dma_addr_gen: loadable up/down word-address counter wrapping modulo 2^W
// Ports: clk, rst (async, active-high); load_i/load_val_i preset the counter;
// step_i advances it by one in the direction dir_i; addr_o is the current value.
module sram_dma_addr_gen
  import sram_dma_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_i,
  input  logic         dir_i,
  output logic [W-1:0] addr_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i :
                      step_i ? (dir_i == DIR_DOWN ? cnt_q - W'(1) : cnt_q + W'(1)) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign addr_o = cnt_q;
endmodule

// File: rtl/sram_dma_copy.sv
// sram_dma_copy: SRAM block copy/fill engine driving a single-port word-addressed SRAM bus
// Ports: pclk, rst (async, active-high); start/abort/mode/dir/src_addr/dst_addr/len/fill_value
// describe a transfer; busy/done/aborted/words_done report progress; address/write_enable/
// write_data/lower_byte/upper_byte/read_data form the SRAM controller bus.
module sram_dma_copy
  import sram_dma_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 20,
  parameter int RD_LAT = 1
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic              dir,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  words_done,
  output logic [ADDR_W-1:0] address,
  output logic              write_enable,
  output logic [DATA_W-1:0] write_data,
  output logic              lower_byte,
  output logic              upper_byte,
  input  logic [DATA_W-1:0] read_data
);
  logic [2:0]        state_q, state_d;
  logic              mode_q, dir_q, aborted_q;
  logic [LEN_W-1:0]  len_q, words_done_q;
  logic [DATA_W-1:0] fill_q, data_q;
  logic [1:0]        lat_q;
  logic [ADDR_W-1:0] src, dst;
  logic              accept, wait_end, last, in_write;
  // start together with abort never launches a transfer
  assign accept   = state_q == ST_IDLE && start && !abort;
  assign wait_end = state_q == ST_WAIT && lat_q == 2'(RD_LAT - 1);
  assign last     = words_done_q + LEN_W'(1) == len_q;
  assign in_write = state_q == ST_WRITE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = !accept ? ST_IDLE : len == '0 ? ST_FINISH :
                          mode == MODE_FILL ? ST_WRITE : ST_READ;
      ST_READ:  state_d = abort ? ST_FINISH : ST_WAIT;
      ST_WAIT:  state_d = abort ? ST_FINISH : wait_end ? ST_WRITE : ST_WAIT;
      ST_WRITE: state_d = (abort || last) ? ST_FINISH : mode_q == MODE_FILL ? ST_WRITE : ST_READ;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_COPY;
      dir_q        <= DIR_UP;
      len_q        <= '0;
      fill_q       <= '0;
      data_q       <= '0;
      lat_q        <= '0;
      words_done_q <= '0;
      aborted_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= state_q == ST_WAIT ? lat_q + 2'd1 : 2'd0;
      if (accept) begin
        mode_q       <= mode;
        dir_q        <= dir;
        len_q        <= len;
        fill_q       <= fill_value;
        words_done_q <= '0;
        aborted_q    <= 1'b0;
      end
      if (wait_end) data_q <= read_data;
      if (in_write) words_done_q <= words_done_q + LEN_W'(1);
      if (abort && busy) aborted_q <= 1'b1;
    end
  sram_dma_addr_gen #(.W(ADDR_W)) u_src (
    .clk(pclk), .rst(rst), .load_i(accept), .load_val_i(src_addr),
    .step_i(in_write), .dir_i(dir_q), .addr_o(src)
  );
  sram_dma_addr_gen #(.W(ADDR_W)) u_dst (
    .clk(pclk), .rst(rst), .load_i(accept), .load_val_i(dst_addr),
    .step_i(in_write), .dir_i(dir_q), .addr_o(dst)
  );
  // bus outputs decode straight from the state so reset removes write_enable at once
  assign busy         = state_q == ST_READ || state_q == ST_WAIT || in_write;
  assign done         = state_q == ST_FINISH;
  assign aborted      = done && aborted_q;
  assign words_done   = words_done_q;
  assign address      = state_q == ST_READ ? src : in_write ? dst : '0;
  assign write_enable = in_write;
  assign write_data   = !in_write ? '0 : mode_q == MODE_FILL ? fill_q : data_q;
  assign lower_byte   = 1'b1;
  assign upper_byte   = 1'b1;
endmodule

// File: doc/sram_dma_copy.md
SRAM_DMA_COPY -- requirements
Module: sram_dma_copy

Interface
REQ-001 Parameter ADDR_W, default 19, SRAM word-address width.
REQ-002 Parameter DATA_W, default 16, SRAM word width.
REQ-003 Parameter LEN_W, default 20, transfer-length width in words (range 0..2^ADDR_W).
REQ-004 Parameter RD_LAT, default 1, range 1..3; cycles from read address presented to read_data valid.
REQ-005 The clock port SHALL be pclk, input, 1 bit; all logic rises on posedge pclk.
REQ-006 The reset port SHALL be rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 start  in  1: request transfer; sampled only in IDLE.
REQ-008 abort  in  1: terminate active transfer.
REQ-009 mode  in  1: 0 = copy, 1 = fill.
REQ-010 dir  in  1: 0 = addresses increment, 1 = addresses decrement.
REQ-011 src_addr, dst_addr  in  ADDR_W: first source/destination word; len  in  LEN_W: word count; fill_value  in  DATA_W.
REQ-012 busy  out  1: high from the cycle after an accepted start until done.
REQ-013 done  out  1: one-cycle pulse on completion or abort; aborted  out  1: valid with done.
REQ-014 words_done  out  LEN_W: count of completed writes in the current or last transfer.
REQ-015 address  out  ADDR_W; write_enable  out  1; write_data  out  DATA_W; lower_byte, upper_byte  out  1; read_data  in  DATA_W: local bus to the SRAM controller.

Function
REQ-016 States SHALL be IDLE, READ, WAIT, WRITE, FINISH.
REQ-017 IDLE, start=1, len>0 -> READ (copy) or WRITE (fill); start=1 with len=0 -> FINISH with no bus write.
REQ-018 Inputs src_addr, dst_addr, len, mode, dir, fill_value SHALL be latched on the accepting cycle; later changes are ignored.
REQ-019 READ drives address=current src, write_enable=0, for one cycle, then enters WAIT.
REQ-020 WAIT lasts RD_LAT cycles; read_data SHALL be captured on its final cycle, then the state goes to WRITE.
REQ-021 WRITE drives address=current dst, write_enable=1, write_data=captured word (copy) or fill_value (fill), for one cycle.
REQ-022 Copy throughput SHALL be one word per 2+RD_LAT cycles; fill throughput one word per cycle (consecutive WRITE cycles).
REQ-023 After each WRITE, src and dst SHALL step by +1 (dir=0) or -1 (dir=1), wrapping modulo 2^ADDR_W, and words_done increments.
REQ-024 When words_done reaches len the state goes to FINISH; otherwise READ (copy) or WRITE (fill).
REQ-025 FINISH pulses done for one cycle and returns to IDLE; busy drops in the same cycle.
REQ-026 abort in READ or WAIT -> FINISH without writing; abort in WRITE lets that write complete, then FINISH; aborted=1.
REQ-027 start while busy SHALL be ignored; start and abort together in IDLE SHALL start nothing.
REQ-028 Outside WRITE, write_enable SHALL be 0; lower_byte=upper_byte=1 always.

Reset
REQ-029 On rst: state=IDLE; busy, done, aborted, write_enable=0; address, write_data, words_done=0; lower_byte, upper_byte=1.
REQ-030 rst mid-transfer SHALL drop write_enable immediately; no further writes occur.

Structure
REQ-031 Package sram_dma_pkg SHALL hold the state enumeration and the MODE_COPY/MODE_FILL and DIR_UP/DIR_DOWN constants.
REQ-032 One sub-module, sram_dma_addr_gen, SHALL hold the loadable up/down wrapping address counter, instantiated twice (src, dst).

Verification
REQ-033 Copy, RD_LAT=1: src=0x100, dst=0x200, len=4, dir=0 -> writes to 0x200..0x203 hold memory[0x100..0x103]; done in cycle 13 after start.
REQ-034 Copy down, overlapping: src=0x010, dst=0x012, len=3, dir=1, memory[0x00E..0x010]=A,B,C -> memory[0x010..0x012]=A,B,C.
REQ-035 Fill: dst=0x7FFFE, len=4, dir=0, fill_value=0xBEEF -> writes at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001 on 4 consecutive cycles.
REQ-036 len=0 -> done pulse with words_done=0, write_enable never asserted.
REQ-037 Abort in WAIT of word 3 (len=10) -> words_done=2, aborted=1, no third write; new start then accepted.
REQ-038 rst during WRITE -> write_enable 0 before next edge; all outputs at reset values.
